// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared FIFO, with packet burst lock
// and a MAX_BURST cut so one long packet cannot starve the other requesters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int BCW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic                          burst_cut
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           busy_q;
  logic           burst_cut_q, burst_cut_d;

  logic                                   pick_found;
  logic [IDW-1:0]                         pick_idx;
  logic [IDW:0]                           scan;
  logic [IDW-1:0]                         sel_idx;
  logic                                   sel_vld;
  logic [IDW-1:0]                         nxt_ptr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     lane_data;

  // Round-robin pick: scan from rr_ptr upward; walking down the offsets lets
  // the nearest valid requester overwrite farther ones.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (req_valid[scan[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IDW-1:0];
      end
    end
  end

  // While locked only the owner is eligible; reset forces the write off.
  always_comb begin
    sel_idx = (state_q == LOCKED) ? owner_q : pick_idx;
    sel_vld = (state_q == LOCKED) ? req_valid[owner_q] : pick_found;
    w_en    = wrst_n & sel_vld & ~full;
    nxt_ptr = (sel_idx == IDW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Per-requester ready and data gating; data_in is the OR of the gated lanes.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_ready[i] = w_en & (sel_idx == IDW'(i));
    assign lane_data[i] = req_ready[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Collapse the one-hot gated lanes onto the FIFO data bus.
  always_comb begin
    data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) data_in = data_in | lane_data[i];
  end

  assign grant_id  = w_en ? sel_idx : '0;
  assign busy      = busy_q;
  assign burst_cut = burst_cut_q;

  // Next-state: lock on a non-final beat, release on last beat or MAX_BURST.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cut_d = 1'b0;
    if (w_en) begin
      case (state_q)
        IDLE: begin
          if (req_last[sel_idx]) begin
            rr_ptr_d = nxt_ptr;
          end else if (MAX_BURST == 1) begin
            rr_ptr_d    = nxt_ptr;
            burst_cut_d = 1'b1;
          end else begin
            state_d    = LOCKED;
            owner_d    = sel_idx;
            beat_cnt_d = BCW'(1);
          end
        end
        LOCKED: begin
          if (req_last[owner_q]) begin
            state_d    = IDLE;
            rr_ptr_d   = nxt_ptr;
            beat_cnt_d = '0;
          end else if (beat_cnt_q + BCW'(1) == BCW'(MAX_BURST)) begin
            state_d     = IDLE;
            rr_ptr_d    = nxt_ptr;
            beat_cnt_d  = '0;
            burst_cut_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset drops any lock and restarts from requester 0.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      burst_cut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= (state_d == LOCKED);
      burst_cut_q <= burst_cut_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            full, w_en, busy, burst_cut;
  logic [DW-1:0]   data_in;
  logic [1:0]      grant_id;

  int n_chk = 0;
  int n_pass = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .full(full), .w_en(w_en),
    .data_in(data_in), .grant_id(grant_id), .busy(busy), .burst_cut(burst_cut)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic set_d(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Behavioural model: who holds the port (-1 = nobody), where the next
  // round-robin search starts, beats delivered in the current lock.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  bit m_cut   = 0;

  function automatic void m_pick(output bit f, output int w);
    f = 0;
    w = 0;
    if (m_owner >= 0) begin
      f = req_valid[m_owner];
      w = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!f && req_valid[j]) begin
          f = 1;
          w = j;
        end
      end
    end
  endfunction

  bit mf;
  int mw;
  always @(posedge wclk) begin
    if (!wrst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_beats <= 0;
      m_cut   <= 0;
    end else begin
      m_pick(mf, mw);
      m_cut <= 0;
      if (mf && !full) begin
        if (m_owner < 0) begin
          if (req_last[mw]) m_ptr <= (mw + 1) % N;
          else begin
            m_owner <= mw;
            m_beats <= 1;
          end
        end else if (req_last[mw] || m_beats + 1 == MB) begin
          m_owner <= -1;
          m_ptr   <= (mw + 1) % N;
          m_beats <= 0;
          m_cut   <= !req_last[mw];
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  bit          cf;
  int          cw;
  bit          e_we;
  logic [N-1:0] e_rdy;
  logic [DW-1:0] e_dat;
  logic [1:0]  e_gid;
  always @(negedge wclk) begin
    m_pick(cf, cw);
    e_we  = wrst_n && cf && !full;
    e_rdy = e_we ? N'(1) << cw : '0;
    e_dat = e_we ? req_data[cw*DW +: DW] : '0;
    e_gid = e_we ? 2'(cw) : 2'd0;
    chk("m_wen",   w_en,      e_we);
    chk("m_ready", req_ready, e_rdy);
    chk("m_data",  data_in,   e_dat);
    chk("m_gid",   grant_id,  e_gid);
    chk("m_busy",  busy,      wrst_n && (m_owner >= 0));
    chk("m_cut",   burst_cut, wrst_n && m_cut);
  end

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  int cut_gid[7] = '{0, 0, 0, 0, 1, 0, 0};
  int beat;

  initial begin
    wrst_n = 1'b0;
    full = 1'b0;
    req_valid = '1;
    req_last = '1;
    req_data = '0;
    for (int i = 0; i < N; i++) set_d(i, 32'hA0 + i);

    // Reset holds the port closed even with every requester valid
    @(negedge wclk);
    chk("rst_wen", w_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    tick(); tick();
    wrst_n = 1'b1;

    // Round robin with single-beat packets, starting at requester 0
    for (int k = 0; k < 6; k++) begin
      @(negedge wclk);
      chk("rr_gid", grant_id, rr_exp[k]);
      chk("rr_wen", w_en, 1);
      if (k == 0) chk("rel_data", data_in, 32'hA0);
      tick();
    end

    // Burst lock: req1 A,B,C while req2 waits
    req_valid = 4'b0010; req_last = 4'b0000; set_d(1, 32'hB1A);
    @(negedge wclk); chk("bl_gidA", grant_id, 1); chk("bl_busyA", busy, 0);
    tick();
    req_valid = 4'b0110; req_last = 4'b0100; set_d(1, 32'hB1B); set_d(2, 32'hC2);
    @(negedge wclk); chk("bl_gidB", grant_id, 1); chk("bl_dataB", data_in, 32'hB1B);
    chk("bl_rdyB", req_ready, 4'b0010); chk("bl_busyB", busy, 1);
    tick();
    req_last = 4'b0110; set_d(1, 32'hB1C);
    @(negedge wclk); chk("bl_gidC", grant_id, 1); chk("bl_dataC", data_in, 32'hB1C); chk("bl_busyC", busy, 1);
    tick();
    req_valid = 4'b0100;
    @(negedge wclk); chk("bl_gid2", grant_id, 2); chk("bl_data2", data_in, 32'hC2); chk("bl_busy2", busy, 0);
    tick();

    // Backpressure mid-burst of req3
    req_valid = 4'b1000; req_last = 4'b0000; set_d(3, 32'hD1);
    @(negedge wclk); chk("bp_gid1", grant_id, 3);
    tick();
    full = 1'b1; req_valid = 4'b1111;
    @(negedge wclk); chk("bp_wen_f1", w_en, 0); chk("bp_busy_f1", busy, 1);
    tick();
    @(negedge wclk); chk("bp_wen_f2", w_en, 0); chk("bp_rdy_f2", req_ready, 0); chk("bp_busy_f2", busy, 1);
    tick();
    full = 1'b0; req_last = 4'b1000; set_d(3, 32'hD2);
    @(negedge wclk); chk("bp_gid2", grant_id, 3); chk("bp_data2", data_in, 32'hD2); chk("bp_rdy2", req_ready, 4'b1000);
    tick();
    full = 1'b1; req_last = 4'b1111;
    @(negedge wclk); chk("bp_idle_wen", w_en, 0); chk("bp_idle_busy", busy, 0);
    tick();
    full = 1'b0;
    @(negedge wclk); chk("bp_idle_gid", grant_id, 0);
    tick();

    // Burst cut: req0 streams 6 beats, req1 slips in after beat 4
    set_d(1, 32'h200);
    beat = 1;
    for (int c = 0; c < 7; c++) begin
      req_valid = {2'b00, (c >= 1 && c <= 4), 1'b1};
      req_last  = {2'b00, 1'b1, (beat == 6)};
      set_d(0, 32'h100 + beat);
      @(negedge wclk);
      chk("bc_wen", w_en, 1);
      chk("bc_gid", grant_id, cut_gid[c]);
      chk("bc_cut", burst_cut, (c == 4));
      chk("bc_data", data_in, (c == 4) ? 32'h200 : 32'h100 + beat);
      if (c == 4) chk("bc_busy", busy, 0);
      tick();
      if (c != 4) beat++;
    end
    req_valid = '0;

    // Reset in the middle of a req2 burst
    req_valid = 4'b0100; req_last = 4'b0000; set_d(2, 32'hE1);
    @(negedge wclk); chk("rm_gid1", grant_id, 2);
    tick();
    set_d(2, 32'hE2);
    @(negedge wclk); chk("rm_gid2", grant_id, 2);
    tick();
    wrst_n = 1'b0; req_valid = 4'b0101;
    @(negedge wclk); chk("rm_wen", w_en, 0); chk("rm_busy", busy, 0); chk("rm_rdy", req_ready, 0);
    tick();
    wrst_n = 1'b1;
    @(negedge wclk); chk("rm_gid0", grant_id, 0); chk("rm_wen0", w_en, 1);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(3) != 0);
        req_last[i]  = ($urandom_range(2) == 0);
        set_d(i, $urandom);
      end
      full   = ($urandom_range(4) == 0);
      wrst_n = ($urandom_range(299) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the FIFO memory among NUM_REQ write-side requesters.
- Runs entirely in the write clock domain and sits between the requesters and the FIFO write port (w_en / data_in, gated by full).
- Round-robin arbitration with optional multi-beat burst lock, so a requester's packet lands contiguously in the FIFO.
- A burst that exceeds MAX_BURST beats is cut to bound latency for the other requesters.

Parameters:
- NUM_REQ, 4: number of requesters (>=2).
- DATA_WIDTH, 32: write data width; matches FIFO data width.
- MAX_BURST, 16: maximum beats per lock (>=1).

Ports:
- wclk  in  1: write-domain clock.
- wrst_n  in  1: reset; asynchronous, active-low.
- req_valid  in  NUM_REQ: per-requester beat valid.
- req_last  in  NUM_REQ: per-requester final beat of packet; sampled only with valid.
- req_data  in  NUM_REQ*DATA_WIDTH: packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ: beat accepted this cycle (one-hot or zero).
- full  in  1: FIFO full flag from write-pointer logic.
- w_en  out  1: FIFO write enable.
- data_in  out  DATA_WIDTH: FIFO write data.
- grant_id  out  $clog2(NUM_REQ): index of the requester written this cycle; valid only when w_en=1, 0 otherwise.
- busy  out  1: registered; 1 while in LOCKED.
- burst_cut  out  1: registered one-cycle pulse when a burst is terminated by MAX_BURST.

Behaviour:
- State registers: state {IDLE, LOCKED}, rr_ptr, owner, beat_cnt (width $clog2(MAX_BURST+1)), burst_cut.
- Async reset: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, busy=0, burst_cut=0.
- While wrst_n=0: w_en, req_ready, data_in and grant_id are all forced to 0, regardless of inputs.
- Accept: a beat is accepted when w_en=1.
  - w_en and req_ready[W] are combinational, with zero-cycle latency from valid to write.
  - w_en=1 implies req_ready[W]=1 and data_in=req_data[W] for the selected W.
  - data_in=0 when w_en=0.
- IDLE: W = first i with req_valid[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
  - No valid request, or full=1: w_en=0, all ready=0; state, rr_ptr and owner hold.
  - Accepted beat with req_last[W]=1: stay IDLE; rr_ptr <= (W+1) mod NUM_REQ.
  - Accepted beat with req_last[W]=0 and MAX_BURST=1: stay IDLE; rr_ptr <= W+1; burst_cut pulses.
  - Accepted beat with req_last[W]=0 and MAX_BURST>1: go to LOCKED; owner <= W; beat_cnt <= 1.
- LOCKED: only owner is eligible; all other ready=0 even when the owner is idle.
  - w_en = req_valid[owner] & !full.
  - Owner valid low: bubble, hold lock. No timeout.
  - full=1: hold everything, no write.
  - Accepted beat with req_last=1: go to IDLE; rr_ptr <= (owner+1) mod NUM_REQ; beat_cnt <= 0.
  - Accepted beat with req_last=0 and beat_cnt+1 == MAX_BURST: go to IDLE; rr_ptr <= owner+1; burst_cut <= 1 for exactly one cycle. The remainder of the packet re-arbitrates as a new burst.
  - Otherwise, on accept: beat_cnt <= beat_cnt+1.
- busy mirrors state==LOCKED, registered, so it rises the cycle after the first beat of a locked burst.
- Full/write rule:
  - w_en is never asserted while full=1, so a write is never dropped by the FIFO.
  - full changing mid-burst only stalls the burst; it never breaks the lock.
- Reset mid-burst drops the lock with no further writes; arbitration restarts from requester 0.
- Fairness: with all requesters continuously valid and single-beat packets, each gets exactly 1 write per NUM_REQ cycles.

Test Plan:
- Reset: all req_valid=1 during wrst_n=0 -> w_en=0, req_ready=0000. First cycle after release: grant_id=0, data_in=req_data[0].
- Round robin: all 4 valid, req_last=1111, full=0 -> grant_id 0,1,2,3,0,1 on consecutive cycles, w_en held at 1.
- Burst lock: req1 sends beats A,B,C (last on C) while req2 valid -> writes A,B,C from id 1, then id 2. busy=1 for 2 cycles. req_ready[2]=0 during the burst.
- Backpressure: full=1 for 2 cycles mid-burst of req3 -> w_en=0, state stays LOCKED, owner=3. Burst resumes with req3's next beat. full=1 in IDLE leaves rr_ptr unchanged.
- Burst cut: MAX_BURST=4, req0 streams 6 beats with last only on beat 6, req1 valid -> 4 writes from id 0, burst_cut pulses once, then id 1 is granted, then req0's remaining 2 beats.
- Reset mid-burst: assert wrst_n=0 after 2 beats of req2 -> w_en drops immediately, busy=0. After release with req0 and req2 valid, grant_id=0 first.
